// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU opcodes, multiplier state encoding and step count.
package ex_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_XOR = 3'b100;
    localparam logic [2:0] ALU_OP_SLT = 3'b101;
    localparam logic [2:0] ALU_OP_SLL = 3'b110;
    localparam logic [2:0] ALU_OP_SRL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned MUL_STEPS = 32;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } mul_state_e;

endpackage

// File: rtl/ex_mul_seq_if.sv
// Signals between the EX stage (master) and the sequential multiplier (slave).
interface ex_mul_seq_if;
    logic        mul_req;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        stall;
    logic        mul_done;
    logic [31:0] mul_res;

    modport master (
        output mul_req, flush, op_a, op_b, alu_res,
        input  alu_own, alu_a, alu_b, alu_op, stall, mul_done, mul_res
    );

    modport slave (
        input  mul_req, flush, op_a, op_b, alu_res,
        output alu_own, alu_a, alu_b, alu_op, stall, mul_done, mul_res
    );
endinterface

// File: rtl/ex_mul_seq.sv
// Shift-add MUL controller that borrows the EX-stage ALU adder one step per cycle.
// Define EX_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module ex_mul_seq
    import ex_pkg::*;
(
    input logic          clk,
    input logic          rst,
    ex_mul_seq_if.slave  mul_if
);

    localparam logic [5:0] LastCnt = 6'(MUL_STEPS - 1);

    mul_state_e  state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mul_res_q, mul_res_d;

    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        stall;
    logic        mul_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mul_res_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mul_res_q <= mul_res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mul_res_d = mul_res_q;
        alu_own   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        stall     = 1'b0;
        mul_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall = mul_if.mul_req & ~mul_if.flush;
                if (mul_if.mul_req && !mul_if.flush) begin
                    mcand_d  = mul_if.op_a;
                    mplier_d = mul_if.op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                alu_own = 1'b1;
                alu_a   = acc_q;
                alu_b   = mcand_q;
                alu_op  = ALU_OP_ADD;
                // A flush releases the pipeline in the same cycle.
                stall   = ~mul_if.flush;
                if (mul_if.flush) begin
                    state_d = StIdle;
`ifdef EX_MUL_EARLY_TERM_EN
                end else if (mplier_q == '0) begin
                    state_d   = StDone;
                    mul_res_d = acc_q;
`endif
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = mul_if.alu_res;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == LastCnt) begin
                        state_d   = StDone;
                        mul_res_d = acc_d;
                    end
                end
            end
            StDone: begin
                // Request is ignored here so the retiring instruction never relaunches.
                mul_done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mul_if.alu_own  = alu_own;
    assign mul_if.alu_a    = alu_a;
    assign mul_if.alu_b    = alu_b;
    assign mul_if.alu_op   = alu_op;
    assign mul_if.stall    = stall;
    assign mul_if.mul_done = mul_done;
    assign mul_if.mul_res  = mul_res_q;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Self-checking bench for ex_mul_seq: cycle model from product arithmetic plus literal pins.
module tb_ex_mul_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    bit   chk_en;

    ex_mul_seq_if ifc ();

    ex_mul_seq dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: anything other than ADD gives a distinguishable wrong answer.
    assign ifc.alu_res = (ifc.alu_op == 3'b000) ? ifc.alu_a + ifc.alu_b : ifc.alu_a ^ ifc.alu_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int run_len(input logic [31:0] b);
`ifdef EX_MUL_EARLY_TERM_EN
        int bl = 0;
        for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
        return (bl + 1 > 32) ? 32 : bl + 1;
`else
        return 32;
`endif
    endfunction

    function automatic logic [31:0] partial(input logic [31:0] a, input logic [31:0] b,
                                            input int k);
        logic [31:0] mask;
        mask = (k == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - k));
        return a * (b & mask);
    endfunction

    // Behavioural model: phase 0 idle, 1 multiplying, 2 result cycle.
    int          m_phase = 0;
    int          m_k = 0;
    int          m_len = 32;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_res   = '0;
        end else begin
            case (m_phase)
                0: if (ifc.mul_req && !ifc.flush) begin
                    m_phase = 1;
                    m_a     = ifc.op_a;
                    m_b     = ifc.op_b;
                    m_k     = 0;
                    m_len   = run_len(ifc.op_b);
                end
                1: if (ifc.flush) m_phase = 0;
                   else begin
                       m_k++;
                       if (m_k == m_len) begin
                           m_phase = 2;
                           m_res   = m_a * m_b;
                       end
                   end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_own;
            logic        e_stall;
            logic        e_done;
            logic [31:0] e_a;
            logic [31:0] e_b;
            e_own   = (m_phase == 1);
            e_done  = (m_phase == 2);
            e_stall = (m_phase == 2) ? 1'b0 : (ifc.mul_req || m_phase == 1) && !ifc.flush;
            e_a     = e_own ? partial(m_a, m_b, m_k) : 32'd0;
            e_b     = e_own ? (m_a << m_k) : 32'd0;
            chk("stall", {31'd0, ifc.stall}, {31'd0, e_stall});
            chk("alu_own", {31'd0, ifc.alu_own}, {31'd0, e_own});
            chk("mul_done", {31'd0, ifc.mul_done}, {31'd0, e_done});
            chk("alu_a", ifc.alu_a, e_a);
            chk("alu_b", ifc.alu_b, e_b);
            chk("alu_op", {29'd0, ifc.alu_op}, 32'd0);
            chk("mul_res", ifc.mul_res, m_res);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int lat);
        bit ok = 0;
        ifc.op_a    = a;
        ifc.op_b    = b;
        ifc.mul_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 100 && !ok; i++) begin
            tick();
            if (ifc.mul_done) begin
                lat = i;
                ok  = 1;
            end
        end
        ifc.mul_req = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no mul_done expected pulse within 100 cycles");
        end
    endtask

    localparam int LatB3 = `ifdef EX_MUL_EARLY_TERM_EN 4 `else 33 `endif;
    localparam int LatB0 = `ifdef EX_MUL_EARLY_TERM_EN 2 `else 33 `endif;

    initial begin
        int          lat;
        int          ndone;
        logic [31:0] a;
        logic [31:0] b;
        n_cmp = 0;
        n_fail = 0;
        chk_en = 0;
        rst = 1'b1;
        ifc.mul_req = 1'b0;
        ifc.flush = 1'b0;
        ifc.op_a = '0;
        ifc.op_b = '0;
        repeat (2) tick();
        chk_en = 1;
        chk("rst_stall", {31'd0, ifc.stall}, 32'd0);
        chk("rst_own", {31'd0, ifc.alu_own}, 32'd0);
        chk("rst_res", ifc.mul_res, 32'd0);
        rst = 1'b0;
        tick();

        do_mul(32'd7, 32'd6, lat);
        chk("lat_7x6", 32'(lat), 32'd33);
        chk("res_7x6", ifc.mul_res, 32'd42);
        tick();
        do_mul(32'hFFFF_FFFD, 32'd5, lat);
        chk("res_neg3x5", ifc.mul_res, 32'hFFFF_FFF1);
        tick();
        do_mul(32'h0001_0000, 32'h0001_0000, lat);
        chk("res_wrap", ifc.mul_res, 32'h0000_0000);
        tick();
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("res_ones", ifc.mul_res, 32'h0000_0001);
        tick();

        // Flush at T+10 of a long operation.
        ifc.op_a = 32'd9;
        ifc.op_b = 32'hFFFF_FFFF;
        ifc.mul_req = 1'b1;
        repeat (10) tick();
        ifc.flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, ifc.stall}, 32'd0);
        tick();
        ifc.flush = 1'b0;
        ifc.mul_req = 1'b0;
        chk("flush_own", {31'd0, ifc.alu_own}, 32'd0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (ifc.mul_done) ndone++;
        end
        chk("flush_no_done", 32'(ndone), 32'd0);
        chk("flush_res_kept", ifc.mul_res, 32'd1);

        // Reset at T+5 of a new operation.
        ifc.op_a = 32'd3;
        ifc.op_b = 32'd3;
        ifc.mul_req = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        ifc.mul_req = 1'b0;
        tick();
        chk("midrst_stall", {31'd0, ifc.stall}, 32'd0);
        chk("midrst_own", {31'd0, ifc.alu_own}, 32'd0);
        chk("midrst_alu_a", ifc.alu_a, 32'd0);
        chk("midrst_res", ifc.mul_res, 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back: second request already present during the DONE cycle.
        do_mul(32'd2, 32'd3, lat);
        chk("b2b_lat1", 32'(lat), 32'd33);
        chk("b2b_res1", ifc.mul_res, 32'd6);
        chk("b2b_gap_stall", {31'd0, ifc.stall}, 32'd0);
        do_mul(32'd4, 32'd5, lat);
        chk("b2b_lat2", 32'(lat), 32'd34);
        chk("b2b_res2", ifc.mul_res, 32'd20);
        tick();

        // Flush in DONE has no effect.
        do_mul(32'd11, 32'd13, lat);
        ifc.flush = 1'b1;
        #1;
        chk("done_flush_pulse", {31'd0, ifc.mul_done}, 32'd1);
        chk("done_flush_res", ifc.mul_res, 32'd143);
        tick();
        ifc.flush = 1'b0;

        // Flushed request in IDLE does not launch.
        ifc.op_a = 32'd5;
        ifc.op_b = 32'd5;
        ifc.mul_req = 1'b1;
        ifc.flush = 1'b1;
        #1;
        chk("idle_flush_stall", {31'd0, ifc.stall}, 32'd0);
        tick();
        ifc.mul_req = 1'b0;
        ifc.flush = 1'b0;
        chk("idle_flush_own", {31'd0, ifc.alu_own}, 32'd0);
        tick();

        do_mul(32'd9, 32'd3, lat);
        chk("lat_b3", 32'(lat), 32'(LatB3));
        chk("res_b3", ifc.mul_res, 32'd27);
        tick();
        do_mul(32'd123, 32'd0, lat);
        chk("lat_b0", 32'(lat), 32'(LatB0));
        chk("res_b0", ifc.mul_res, 32'd0);
        tick();

        for (int it = 0; it < 25; it++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 255));
                default: b = 32'd0;
            endcase
            do_mul(a, b, lat);
            chk("rand_lat", 32'(lat), 32'(run_len(b) + 1));
            chk("rand_res", ifc.mul_res, a * b);
            repeat ($urandom_range(1, 3)) tick();
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
